mipi_rx_link_ctrl: RTL and testbench
====================================

# mipi_rx_link_ctrl

Link controller for the 2-lane CSI-2 D-PHY receiver and its byte-to-pixel converter, running in the byte clock domain. It powers up the D-PHY, releases its resets in order, and waits for a first Frame Start. It then releases the byte-to-pixel reset on a frame boundary and supervises the link with a packet watchdog and header checks. On loss of link it re-runs the bring-up sequence automatically and publishes status and counters for the control interface.

## Interface
- `PD_CYCLES`, default 64: cycles of power-up with PHY resets held.
- `RST_CYCLES`, default 32: cycles between PHY reset release and start of Frame Start search.
- `TO_W`, default 24: width of the timeout counters.
- `FS_TIMEOUT`, default 24'hFF_FFFF: cycles allowed to see Frame Start after reset release.
- `WDOG_CYCLES`, default 24'h3F_FFFF: cycles without any packet header before link loss is declared.
- `MAX_RETRY`, default 3: consecutive failed bring-ups allowed before FAULT.
- `REF_DT`, default 6'h2B: expected long-packet data type (RAW10).
- `EXP_WC`, default 16'd1600: expected long-packet word count.
- Reset: one clock; reset is synchronous and active-high.
- `clk_byte_i`, in, 1: byte clock (D-PHY `rx_clk_byte_fr`).
- `reset_i`, in, 1: synchronous, active-high.
- `enable_i`, in, 1: level; 1 = bring the link up, 0 = power it down.
- `sp_en_i`, in, 1: short-packet header strobe; `dt_i` is valid with it.
- `lp_av_en_i`, in, 1: long-packet header strobe for data type `REF_DT`; `dt_i` and `wc_i` are valid with it.
- `dt_i`, in, 6: packet data type.
- `wc_i`, in, 16: packet word count.
- `dphy_pd_o`, out, 1: D-PHY power-down.
- `dphy_reset_n_o`, out, 1: D-PHY byte and core resets, active-low.
- `b2p_reset_n_o`, out, 1: byte-to-pixel reset, active-low.
- `link_up_o`, out, 1: link is in ACTIVE.
- `fault_o`, out, 1: retries are exhausted.
- `state_o`, out, 3: state encoding, for debug.
- `frame_cnt_o`, out, 16: completed frames, counted on FE. Wraps.
- `lines_o`, out, 16: long packets in the last complete frame.
- `wc_err_o`, out, 1: sticky flag for a word-count or data-type mismatch.
- `recover_cnt_o`, out, 8: watchdog recoveries. Saturates at 255.
- `clr_i`, in, 1: one-cycle pulse; clears `wc_err_o`, `recover_cnt_o`, `frame_cnt_o` and `fault_o`.

## Operation
- State machine, encoded OFF=0, PWRUP=1, RSTREL=2, WAIT_FS=3, SYNC=4, ACTIVE=5, FAULT=6.
- **OFF**
  - Outputs: `dphy_pd_o`=1, both resets are 0, retry count = 0.
  - Transition: `enable_i`=1 → PWRUP.
- **PWRUP**
  - Outputs: `dphy_pd_o`=0, resets are held.
  - Transition: after `PD_CYCLES` cycles → RSTREL.
- **RSTREL**
  - Outputs: `dphy_reset_n_o`=1.
  - Transition: after `RST_CYCLES` cycles → WAIT_FS.
- **WAIT_FS**
  - Transition: `sp_en_i` with `dt_i`=6'h00 (Frame Start) → SYNC.
  - On timeout, at `FS_TIMEOUT` cycles:
    - retry < `MAX_RETRY`: increment retry, go to PWRUP with PHY reset reasserted and `dphy_pd_o`=1 for that first PWRUP cycle.
    - otherwise → FAULT.
- **SYNC**
  - Waits for Frame End (`dt_i`=6'h01).
  - On Frame End: set `b2p_reset_n_o`=1, clear retry, go to ACTIVE. The converter therefore starts at a frame boundary.
  - The watchdog applies here too.
- **ACTIVE**
  - `link_up_o`=1.
  - Every `sp_en_i` or `lp_av_en_i` reloads the watchdog.
  - Watchdog expiry: increment `recover_cnt_o`, deassert all resets-release signals (`dphy_reset_n_o`=0, `b2p_reset_n_o`=0), go to PWRUP. Retry count starts at 0.
- **FAULT**
  - Outputs: `fault_o`=1, PHY powered down.
  - Left only by `enable_i`=0 (→ OFF) or by `clr_i` (→ OFF).
- `enable_i`=0 in any state → OFF on the next cycle. This takes priority over every other transition.
- **Frame accounting** (ACTIVE only)
  - A line counter is cleared on FS and incremented on each `lp_av_en_i`.
  - On FE: `lines_o` ← line counter, `frame_cnt_o` increments.
- **Header check** (ACTIVE only): `lp_av_en_i` with `dt_i`≠`REF_DT` or `wc_i`≠`EXP_WC` → set `wc_err_o`.
- `sp_en_i` and `lp_av_en_i` in the same cycle: both are processed. A watchdog reload counts once.

## Timing
- All outputs are registered and update one cycle after the causing input or counter terminal value.
- Values after reset: state OFF, `dphy_pd_o`=1, all other outputs 0.
- The PWRUP→RSTREL and RSTREL→WAIT_FS dwell times are exactly `PD_CYCLES` and `RST_CYCLES` cycles, measured from state entry.
- `clr_i` and an increment in the same cycle: the clear wins.
- `reset_i` mid-operation forces the reset values on the next edge regardless of state.
- Timeout counters are `TO_W` bits, count up and compare with `==`. They never wrap because they are cleared on expiry.

## Structure
- A shared package `mipi_rx_pkg` holds:
  - the state enum,
  - the CSI-2 data-type constants `DT_FS`=6'h00, `DT_FE`=6'h01, `DT_RAW10`=6'h2B.
- Sub-module `mipi_rx_hdr_mon` holds the header check, line and frame counters and `lines_o` latch. It is enabled by the FSM's ACTIVE flag.

## Test plan
- **Bring-up:** `enable_i`=1, FS at cycle 200, FE at cycle 300 → `dphy_pd_o` falls 1 cycle after enable, `dphy_reset_n_o` rises 64 cycles later, `b2p_reset_n_o` and `link_up_o` rise 1 cycle after FE, `state_o`=5.
- **Frame accounting:** 3 frames of 720 RAW10 long packets, wc=1600 → `frame_cnt_o`=3, `lines_o`=720, `wc_err_o`=0.
- **Header error:** one long packet with wc=1598 → `wc_err_o`=1 and stays 1. `clr_i` → 0.
- **Watchdog recovery:** headers stop while in ACTIVE → after `WDOG_CYCLES`+1 cycles `link_up_o`=0, `recover_cnt_o`=1, `state_o`=1. Re-sending FS and FE returns the link to ACTIVE.
- **Retry exhaustion:** no FS ever sent, with `FS_TIMEOUT` overridden to 100 → three retries, then `fault_o`=1 and `state_o`=6. `clr_i` → state OFF, then PWRUP.
- **Disable priority and reset:** drop `enable_i` mid-ACTIVE → OFF next cycle. `reset_i` during WAIT_FS → all outputs at reset values.

Source files
------------

// File: rtl/mipi_rx_pkg.sv
// Shared types and CSI-2 constants for the MIPI RX link controller.
package mipi_rx_pkg;

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_PWRUP   = 3'd1,
      ST_RSTREL  = 3'd2,
      ST_WAIT_FS = 3'd3,
      ST_SYNC    = 3'd4,
      ST_ACTIVE  = 3'd5,
      ST_FAULT   = 3'd6
   } state_e;

   localparam logic [5:0] DT_FS    = 6'h00;
   localparam logic [5:0] DT_FE    = 6'h01;
   localparam logic [5:0] DT_RAW10 = 6'h2B;

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned REC_W   = 8;
   localparam int unsigned RETRY_W = 8;

endpackage

// File: rtl/mipi_rx_hdr_mon.sv
// Header checker plus line/frame accounting; only observes traffic while the link is active.
module mipi_rx_hdr_mon
   import mipi_rx_pkg::*;
#(
   parameter logic [5:0]  REF_DT = DT_RAW10,
   parameter logic [15:0] EXP_WC = 16'd1600
) (
   input  logic             clk,
   input  logic             reset_i,
   input  logic             active_i,
   input  logic             clr_i,
   input  logic             sp_en_i,
   input  logic             lp_av_en_i,
   input  logic [5:0]       dt_i,
   input  logic [15:0]      wc_i,
   output logic [CNT_W-1:0] lines_o,
   output logic [CNT_W-1:0] frame_cnt_o,
   output logic             wc_err_o
);

   logic [CNT_W-1:0] line_q, line_d;
   logic [CNT_W-1:0] lines_q, lines_d;
   logic [CNT_W-1:0] frame_q, frame_d;
   logic             err_q, err_d;
   logic             fs, fe;

   always_comb begin
      line_d  = line_q;
      lines_d = lines_q;
      frame_d = frame_q;
      err_d   = err_q;
      fs      = sp_en_i && (dt_i == DT_FS);
      fe      = sp_en_i && (dt_i == DT_FE);
      if (active_i) begin
         // FS restarts the line count; a long packet in the same cycle is its first line
         line_d = (fs ? '0 : line_q) + CNT_W'(lp_av_en_i);
         if (fe) begin
            lines_d = line_q + CNT_W'(lp_av_en_i);
            frame_d = frame_q + CNT_W'(1);
         end
         if (lp_av_en_i && ((dt_i != REF_DT) || (wc_i != EXP_WC))) begin
            err_d = 1'b1;
         end
      end
      if (clr_i) begin
         err_d   = 1'b0;
         frame_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         line_q  <= '0;
         lines_q <= '0;
         frame_q <= '0;
         err_q   <= 1'b0;
      end else begin
         line_q  <= line_d;
         lines_q <= lines_d;
         frame_q <= frame_d;
         err_q   <= err_d;
      end
   end

   assign lines_o     = lines_q;
   assign frame_cnt_o = frame_q;
   assign wc_err_o    = err_q;

endmodule

// File: rtl/mipi_rx_link_ctrl.sv
// D-PHY bring-up, frame-aligned byte-to-pixel release and watchdog recovery for a CSI-2 receiver.
module mipi_rx_link_ctrl
   import mipi_rx_pkg::*;
#(
   parameter int unsigned   PD_CYCLES   = 64,
   parameter int unsigned   RST_CYCLES  = 32,
   parameter int unsigned   TO_W        = 24,
   parameter logic [TO_W-1:0] FS_TIMEOUT  = TO_W'(24'hFF_FFFF),
   parameter logic [TO_W-1:0] WDOG_CYCLES = TO_W'(24'h3F_FFFF),
   parameter int unsigned   MAX_RETRY   = 3,
   parameter logic [5:0]    REF_DT      = DT_RAW10,
   parameter logic [15:0]   EXP_WC      = 16'd1600
) (
   input  logic        clk_byte_i,
   input  logic        reset_i,
   input  logic        enable_i,
   input  logic        sp_en_i,
   input  logic        lp_av_en_i,
   input  logic [5:0]  dt_i,
   input  logic [15:0] wc_i,
   input  logic        clr_i,
   output logic        dphy_pd_o,
   output logic        dphy_reset_n_o,
   output logic        b2p_reset_n_o,
   output logic        link_up_o,
   output logic        fault_o,
   output logic [2:0]  state_o,
   output logic [15:0] frame_cnt_o,
   output logic [15:0] lines_o,
   output logic        wc_err_o,
   output logic [7:0]  recover_cnt_o
);

   state_e             state_q, state_d;
   logic [TO_W-1:0]    cnt_q, cnt_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic [REC_W-1:0]   recover_q, recover_d;
   logic               pd_q, pd_d;
   logic               rstn_q, rstn_d;
   logic               active_q, active_d;
   logic               fault_q, fault_d;
   logic               hdr, fs_seen, fe_seen, wdog_exp, pd_first;

   always_comb begin
      state_d   = state_q;
      retry_d   = retry_q;
      recover_d = recover_q;
      pd_first  = 1'b0;
      wdog_exp  = 1'b0;
      hdr       = sp_en_i | lp_av_en_i;
      fs_seen   = sp_en_i && (dt_i == DT_FS);
      fe_seen   = sp_en_i && (dt_i == DT_FE);

      if (!enable_i) begin
         state_d = ST_OFF;
         retry_d = '0;
      end else begin
         unique case (state_q)
            ST_OFF: begin
               retry_d = '0;
               state_d = ST_PWRUP;
            end
            ST_PWRUP:  if (cnt_q == TO_W'(PD_CYCLES - 1))  state_d = ST_RSTREL;
            ST_RSTREL: if (cnt_q == TO_W'(RST_CYCLES - 1)) state_d = ST_WAIT_FS;
            ST_WAIT_FS: begin
               if (fs_seen) begin
                  state_d = ST_SYNC;
               end else if (cnt_q == FS_TIMEOUT - TO_W'(1)) begin
                  if (retry_q < RETRY_W'(MAX_RETRY)) begin
                     retry_d  = retry_q + RETRY_W'(1);
                     state_d  = ST_PWRUP;
                     pd_first = 1'b1;
                  end else begin
                     state_d = ST_FAULT;
                  end
               end
            end
            ST_SYNC: begin
               if (fe_seen) begin
                  retry_d = '0;
                  state_d = ST_ACTIVE;
               end else if (!hdr && cnt_q == WDOG_CYCLES) begin
                  wdog_exp = 1'b1;
               end
            end
            ST_ACTIVE: if (!hdr && cnt_q == WDOG_CYCLES) wdog_exp = 1'b1;
            ST_FAULT:  if (clr_i) state_d = ST_OFF;
            default:   state_d = ST_OFF;
         endcase
      end

      if (wdog_exp) begin
         state_d = ST_PWRUP;
         retry_d = '0;
         if (recover_q != '1) recover_d = recover_q + REC_W'(1);
      end
      if (clr_i) recover_d = '0;

      // One counter serves dwell, FS timeout and watchdog; it restarts on every state entry
      if (state_d != state_q || state_q == ST_OFF || state_q == ST_FAULT) begin
         cnt_d = '0;
      end else if ((state_q == ST_SYNC || state_q == ST_ACTIVE) && hdr) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + TO_W'(1);
      end

      pd_d     = (state_d == ST_OFF) || (state_d == ST_FAULT) || pd_first;
      rstn_d   = (state_d == ST_RSTREL) || (state_d == ST_WAIT_FS) ||
                 (state_d == ST_SYNC)   || (state_d == ST_ACTIVE);
      active_d = (state_d == ST_ACTIVE);
      fault_d  = (state_d == ST_FAULT);
   end

   always_ff @(posedge clk_byte_i) begin
      if (reset_i) begin
         state_q   <= ST_OFF;
         cnt_q     <= '0;
         retry_q   <= '0;
         recover_q <= '0;
         pd_q      <= 1'b1;
         rstn_q    <= 1'b0;
         active_q  <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retry_q   <= retry_d;
         recover_q <= recover_d;
         pd_q      <= pd_d;
         rstn_q    <= rstn_d;
         active_q  <= active_d;
         fault_q   <= fault_d;
      end
   end

   mipi_rx_hdr_mon #(
      .REF_DT (REF_DT),
      .EXP_WC (EXP_WC)
   ) u_hdr_mon (
      .clk         (clk_byte_i),
      .reset_i     (reset_i),
      .active_i    (active_q),
      .clr_i       (clr_i),
      .sp_en_i     (sp_en_i),
      .lp_av_en_i  (lp_av_en_i),
      .dt_i        (dt_i),
      .wc_i        (wc_i),
      .lines_o     (lines_o),
      .frame_cnt_o (frame_cnt_o),
      .wc_err_o    (wc_err_o)
   );

   assign dphy_pd_o      = pd_q;
   assign dphy_reset_n_o = rstn_q;
   assign b2p_reset_n_o  = active_q;
   assign link_up_o      = active_q;
   assign fault_o        = fault_q;
   assign state_o        = 3'(state_q);
   assign recover_cnt_o  = recover_q;

endmodule

// File: tb/tb_mipi_rx_link_ctrl.sv
// Directed bench for mipi_rx_link_ctrl: bring-up, accounting table, watchdog, retries, disable/reset.
module tb_mipi_rx_link_ctrl;

   localparam int unsigned WDOG = 200;

   logic        clk = 1'b0;
   logic        reset_i, enable_i, sp_en_i, lp_av_en_i, clr_i;
   logic [5:0]  dt_i;
   logic [15:0] wc_i;
   logic        dphy_pd_o, dphy_reset_n_o, b2p_reset_n_o, link_up_o, fault_o, wc_err_o;
   logic [2:0]  state_o;
   logic [15:0] frame_cnt_o, lines_o;
   logic [7:0]  recover_cnt_o;

   int checks = 0;
   int errors = 0;

   mipi_rx_link_ctrl #(
      .PD_CYCLES   (64),
      .RST_CYCLES  (32),
      .TO_W        (24),
      .FS_TIMEOUT  (24'd100),
      .WDOG_CYCLES (24'(WDOG)),
      .MAX_RETRY   (3),
      .REF_DT      (6'h2B),
      .EXP_WC      (16'd1600)
   ) dut (
      .clk_byte_i     (clk),
      .reset_i        (reset_i),
      .enable_i       (enable_i),
      .sp_en_i        (sp_en_i),
      .lp_av_en_i     (lp_av_en_i),
      .dt_i           (dt_i),
      .wc_i           (wc_i),
      .clr_i          (clr_i),
      .dphy_pd_o      (dphy_pd_o),
      .dphy_reset_n_o (dphy_reset_n_o),
      .b2p_reset_n_o  (b2p_reset_n_o),
      .link_up_o      (link_up_o),
      .fault_o        (fault_o),
      .state_o        (state_o),
      .frame_cnt_o    (frame_cnt_o),
      .lines_o        (lines_o),
      .wc_err_o       (wc_err_o),
      .recover_cnt_o  (recover_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sp;
      logic        lp;
      logic [5:0]  dt;
      logic [15:0] wc;
      logic        clr;
      logic [2:0]  e_state;
      logic        e_err;
      logic [15:0] e_frame;
      logic [15:0] e_lines;
   } vec_t;

   vec_t vec [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_sp(input logic [5:0] d);
      sp_en_i = 1'b1; dt_i = d;
      tick();
      sp_en_i = 1'b0;
   endtask

   task automatic send_lp(input logic [5:0] d, input logic [15:0] w);
      lp_av_en_i = 1'b1; dt_i = d; wc_i = w;
      tick();
      lp_av_en_i = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"},   32'(state_o), 32'd0);
      chk({tag, "_pd"},      32'(dphy_pd_o), 32'd1);
      chk({tag, "_rstn"},    32'(dphy_reset_n_o), 32'd0);
      chk({tag, "_b2p"},     32'(b2p_reset_n_o), 32'd0);
      chk({tag, "_link"},    32'(link_up_o), 32'd0);
      chk({tag, "_fault"},   32'(fault_o), 32'd0);
      chk({tag, "_frame"},   32'(frame_cnt_o), 32'd0);
      chk({tag, "_lines"},   32'(lines_o), 32'd0);
      chk({tag, "_err"},     32'(wc_err_o), 32'd0);
      chk({tag, "_recover"}, 32'(recover_cnt_o), 32'd0);
   endtask

   initial begin
      int n;
      int retries;
      logic [2:0] prev;

      //            sp    lp    dt     wc        clr   st    err   frame  lines
      vec[0] = '{1'b0, 1'b1, 6'h2B, 16'd1600, 1'b0, 3'd5, 1'b0, 16'd3, 16'd720};
      vec[1] = '{1'b0, 1'b1, 6'h2B, 16'd1598, 1'b0, 3'd5, 1'b1, 16'd3, 16'd720};
      vec[2] = '{1'b0, 1'b0, 6'h2B, 16'd1600, 1'b0, 3'd5, 1'b1, 16'd3, 16'd720};
      vec[3] = '{1'b0, 1'b1, 6'h2B, 16'd1600, 1'b0, 3'd5, 1'b1, 16'd3, 16'd720};
      vec[4] = '{1'b0, 1'b0, 6'h2B, 16'd1600, 1'b1, 3'd5, 1'b0, 16'd0, 16'd720};
      vec[5] = '{1'b1, 1'b0, 6'h00, 16'd0,    1'b0, 3'd5, 1'b0, 16'd0, 16'd720};
      vec[6] = '{1'b0, 1'b1, 6'h2B, 16'd1600, 1'b0, 3'd5, 1'b0, 16'd0, 16'd720};
      vec[7] = '{1'b0, 1'b1, 6'h2A, 16'd1600, 1'b0, 3'd5, 1'b1, 16'd0, 16'd720};
      vec[8] = '{1'b1, 1'b0, 6'h01, 16'd0,    1'b0, 3'd5, 1'b1, 16'd1, 16'd2};
      vec[9] = '{1'b1, 1'b0, 6'h01, 16'd0,    1'b1, 3'd5, 1'b0, 16'd0, 16'd2};

      reset_i = 1'b1; enable_i = 1'b0; sp_en_i = 1'b0; lp_av_en_i = 1'b0;
      clr_i = 1'b0; dt_i = '0; wc_i = '0;
      idle(2);
      chk_reset_vals("por");
      reset_i = 1'b0;
      idle(3);
      chk("off_idle_state", 32'(state_o), 32'd0);

      // Bring-up with exact dwell times
      enable_i = 1'b1;
      tick();
      chk("bu_pd_fall", 32'(dphy_pd_o), 32'd0);
      chk("bu_pwrup",   32'(state_o), 32'd1);
      idle(63);
      chk("bu_rstn_hold", 32'(dphy_reset_n_o), 32'd0);
      tick();
      chk("bu_rstn_rise", 32'(dphy_reset_n_o), 32'd1);
      chk("bu_rstrel",    32'(state_o), 32'd2);
      idle(31);
      chk("bu_rstrel_hold", 32'(state_o), 32'd2);
      tick();
      chk("bu_wait_fs", 32'(state_o), 32'd3);
      idle(50);
      send_sp(6'h00);
      chk("bu_sync",     32'(state_o), 32'd4);
      idle(99);
      chk("bu_b2p_hold", 32'(b2p_reset_n_o), 32'd0);
      send_sp(6'h01);
      chk("bu_b2p_rise", 32'(b2p_reset_n_o), 32'd1);
      chk("bu_link_up",  32'(link_up_o), 32'd1);
      chk("bu_active",   32'(state_o), 32'd5);

      // Three full frames
      for (int f = 0; f < 3; f++) begin
         send_sp(6'h00);
         for (int l = 0; l < 720; l++) send_lp(6'h2B, 16'd1600);
         send_sp(6'h01);
      end
      chk("fa_frames", 32'(frame_cnt_o), 32'd3);
      chk("fa_lines",  32'(lines_o), 32'd720);
      chk("fa_err",    32'(wc_err_o), 32'd0);

      // Header check, sticky error, clear priority
      for (int i = 0; i < 10; i++) begin
         sp_en_i = vec[i].sp; lp_av_en_i = vec[i].lp; dt_i = vec[i].dt;
         wc_i = vec[i].wc; clr_i = vec[i].clr;
         tick();
         sp_en_i = 1'b0; lp_av_en_i = 1'b0; clr_i = 1'b0;
         chk($sformatf("vec%0d_state", i), 32'(state_o), 32'(vec[i].e_state));
         chk($sformatf("vec%0d_err", i),   32'(wc_err_o), 32'(vec[i].e_err));
         chk($sformatf("vec%0d_frame", i), 32'(frame_cnt_o), 32'(vec[i].e_frame));
         chk($sformatf("vec%0d_lines", i), 32'(lines_o), 32'(vec[i].e_lines));
      end

      // Watchdog: expiry WDOG+1 cycles after the last header
      idle(WDOG);
      chk("wd_still_up", 32'(link_up_o), 32'd1);
      tick();
      chk("wd_link_down", 32'(link_up_o), 32'd0);
      chk("wd_pwrup",     32'(state_o), 32'd1);
      chk("wd_recover",   32'(recover_cnt_o), 32'd1);
      chk("wd_rstn",      32'(dphy_reset_n_o), 32'd0);
      chk("wd_b2p",       32'(b2p_reset_n_o), 32'd0);
      chk("wd_pd",        32'(dphy_pd_o), 32'd0);
      idle(96);
      chk("wd_wait_fs", 32'(state_o), 32'd3);
      send_sp(6'h00);
      idle(5);
      send_sp(6'h01);
      chk("wd_relink", 32'(link_up_o), 32'd1);
      chk("wd_reactive", 32'(state_o), 32'd5);
      lp_av_en_i = 1'b1; dt_i = 6'h2B; wc_i = 16'd1600; clr_i = 1'b1;
      tick();
      lp_av_en_i = 1'b0; clr_i = 1'b0;
      chk("clr_recover", 32'(recover_cnt_o), 32'd0);

      // Disable has priority; reset in WAIT_FS restores reset values
      enable_i = 1'b0;
      tick();
      chk("dis_off",  32'(state_o), 32'd0);
      chk("dis_link", 32'(link_up_o), 32'd0);
      chk("dis_pd",   32'(dphy_pd_o), 32'd1);
      enable_i = 1'b1;
      idle(97);
      chk("rst_pre_wait_fs", 32'(state_o), 32'd3);
      reset_i = 1'b1;
      tick();
      chk_reset_vals("mid_rst");
      reset_i = 1'b0;

      // Retry exhaustion: 4 attempts of 196 cycles, then FAULT
      tick();
      chk("rt_pwrup", 32'(state_o), 32'd1);
      n = 0; retries = 0; prev = state_o;
      while (state_o != 3'd6 && n < 2000) begin
         tick();
         n++;
         if (prev == 3'd3 && state_o == 3'd1) begin
            retries++;
            chk("rt_pd_first", 32'(dphy_pd_o), 32'd1);
         end
         prev = state_o;
      end
      chk("rt_cycles",  32'(n), 32'd784);
      chk("rt_retries", 32'(retries), 32'd3);
      chk("rt_fault",   32'(fault_o), 32'd1);
      chk("rt_state",   32'(state_o), 32'd6);
      chk("rt_pd",      32'(dphy_pd_o), 32'd1);
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      chk("clr_off",   32'(state_o), 32'd0);
      chk("clr_fault", 32'(fault_o), 32'd0);
      tick();
      chk("clr_pwrup", 32'(state_o), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
